ack_bus_requester: RTL and testbench

ACK_BUS_REQUESTER -- requirements
Module: ack_bus_requester

---
 rtl/ack_bus_pkg.sv | 15 +
 rtl/ack_bus_requester.sv | 134 +++++++++++++
 tb/tb_ack_bus_requester.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ack_bus_pkg.sv
// Shared ack-bus definitions: source IDs and the requester FSM state encoding.
package ack_bus_pkg;

  localparam logic [1:0] ID_MEM  = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_AES  = 2'b10;
  localparam logic [1:0] ID_CTRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_GAP  = 2'b10
  } req_state_e;

endpackage

// File: rtl/ack_bus_requester.sv
// Per-source ack-bus requester: queues completion pulses as pending acks and
// requests the shared ack bus until each one is accepted.
//
// state | meaning
// IDLE  | nothing pending, bus not requested
// REQ   | req_o high, waiting for a qualified grant
// GAP   | one-cycle bus release after an accepted ack
module ack_bus_requester
  import ack_bus_pkg::*;
#(
  parameter logic [1:0]  SOURCE_ID   = ID_MEM,
  parameter int unsigned PEND_W      = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_i,
  input  logic              clr_i,
  output logic              req_o,
  input  logic              ack_ready_i,
  input  logic [1:0]        winner_source_id_i,
  input  logic              ack_event_i,
  output logic              ack_sent_o,
  output logic [PEND_W-1:0] pend_cnt_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              timeout_o,
  output logic              proto_err_o
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(TIMEOUT_CYC);

  req_state_e        r_state;
  req_state_e        w_state_nxt;
  logic              r_req;
  logic              r_ack_sent;
  logic [PEND_W-1:0] r_pend;
  logic [WAIT_W-1:0] r_wait;
  logic              r_overflow;
  logic              r_timeout;
  logic              r_proto;

  logic w_accept;
  logic w_proto_set;
  logic w_pend_nz;
  logic w_full;
  logic w_ovf_set;
  logic w_to_set;
  logic w_enter_req;

  // A grant only counts when fully qualified and we are actually requesting;
  // any other grant assertion is a protocol error.
  assign w_accept    = ack_ready_i & ack_event_i & (winner_source_id_i == SOURCE_ID) & r_req;
  assign w_proto_set = ack_ready_i & ~w_accept;
  assign w_pend_nz   = (r_pend != '0);
  assign w_full      = (r_pend == PEND_MAX);
  assign w_ovf_set   = done_i & w_full & ~w_accept;
  // Timeout fires once, on the cycle the wait count reaches the limit.
  assign w_to_set    = (r_state == ST_REQ) & ~w_accept & (r_wait == WAIT_LAST);
  assign w_enter_req = (w_state_nxt == ST_REQ) & (r_state != ST_REQ);

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pend_nz || done_i) w_state_nxt = ST_REQ;
      ST_REQ:  if (w_accept)            w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = (w_pend_nz || done_i) ? ST_REQ : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered request and ack-sent pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_ack_sent <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= (w_state_nxt == ST_REQ);
      r_ack_sent <= w_accept;
    end
  end

  // Pending-ack counter; saturates at both ends, done+accept cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (done_i && !w_accept && !w_full) begin
      r_pend <= r_pend + PEND_ONE;
    end else if (w_accept && !done_i && w_pend_nz) begin
      r_pend <= r_pend - PEND_ONE;
    end
  end

  // Grant wait counter: restarts on every entry to REQ, saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_enter_req) begin
      r_wait <= '0;
    end else if ((r_state == ST_REQ) && !w_accept && (r_wait != WAIT_SAT)) begin
      r_wait <= r_wait + WAIT_ONE;
    end
  end

  // Sticky flags; a set condition in the same cycle beats clr_i.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_proto    <= 1'b0;
    end else begin
      r_overflow <= w_ovf_set   | (r_overflow & ~clr_i);
      r_timeout  <= w_to_set    | (r_timeout  & ~clr_i);
      r_proto    <= w_proto_set | (r_proto    & ~clr_i);
    end
  end

  assign req_o       = r_req;
  assign ack_sent_o  = r_ack_sent;
  assign pend_cnt_o  = r_pend;
  assign busy_o      = (r_state != ST_IDLE);
  assign overflow_o  = r_overflow;
  assign timeout_o   = r_timeout;
  assign proto_err_o = r_proto;

endmodule

// File: tb/tb_ack_bus_requester.sv
// Directed bench for ack_bus_requester (SOURCE_ID=01, PEND_W=2, TIMEOUT_CYC=8).
module tb_ack_bus_requester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done_i;
  logic       clr_i;
  logic       req_o;
  logic       ack_ready_i;
  logic [1:0] winner_source_id_i;
  logic       ack_event_i;
  logic       ack_sent_o;
  logic [1:0] pend_cnt_o;
  logic       busy_o;
  logic       overflow_o;
  logic       timeout_o;
  logic       proto_err_o;

  int checks = 0;
  int errors = 0;

  ack_bus_requester #(
    .SOURCE_ID  (2'b01),
    .PEND_W     (2),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .done_i            (done_i),
    .clr_i             (clr_i),
    .req_o             (req_o),
    .ack_ready_i       (ack_ready_i),
    .winner_source_id_i(winner_source_id_i),
    .ack_event_i       (ack_event_i),
    .ack_sent_o        (ack_sent_o),
    .pend_cnt_o        (pend_cnt_o),
    .busy_o            (busy_o),
    .overflow_o        (overflow_o),
    .timeout_o         (timeout_o),
    .proto_err_o       (proto_err_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    done_i             = 1'b0;
    clr_i              = 1'b0;
    ack_ready_i        = 1'b0;
    ack_event_i        = 1'b0;
    winner_source_id_i = 2'b00;
  endtask

  task automatic grant_good();
    ack_ready_i        = 1'b1;
    ack_event_i        = 1'b1;
    winner_source_id_i = 2'b01;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n  = 1'b0;
    done_i = 1'b1;
    tick();
    tick();
    done_i = 1'b0;
    rst_n  = 1'b1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req_o); end
    checks++; if (pend_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (ack_sent_o !== 1'b0) begin errors++; $display("FAIL reset_ack_sent got=%b exp=0", ack_sent_o); end
    checks++; if ({overflow_o, timeout_o, proto_err_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {overflow_o, timeout_o, proto_err_o}); end
    tick();
    checks++; if (busy_o !== 1'b0 || pend_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_done_ignored got busy=%b pend=%0d exp busy=0 pend=0", busy_o, pend_cnt_o); end
  endtask

  // done at cycle 10, grant at 13: req 11..13, ack_sent at 14, idle at 15.
  task automatic test_single_ack();
    do_reset();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checks++; if (req_o !== 1'b1 || pend_cnt_o !== 2'd1) begin errors++; $display("FAIL single_c11 got req=%b pend=%0d exp req=1 pend=1", req_o, pend_cnt_o); end
    tick();
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL single_c12_req got=%b exp=1", req_o); end
    tick();
    checks++; if (req_o !== 1'b1 || ack_sent_o !== 1'b0) begin errors++; $display("FAIL single_c13 got req=%b ack=%b exp req=1 ack=0", req_o, ack_sent_o); end
    grant_good();
    tick();
    idle_inputs();
    checks++; if (req_o !== 1'b0 || ack_sent_o !== 1'b1 || pend_cnt_o !== 2'd0 || busy_o !== 1'b1) begin errors++; $display("FAIL single_c14 got req=%b ack=%b pend=%0d busy=%b exp 0 1 0 1", req_o, ack_sent_o, pend_cnt_o, busy_o); end
    tick();
    checks++; if (busy_o !== 1'b0 || ack_sent_o !== 1'b0 || req_o !== 1'b0) begin errors++; $display("FAIL single_c15 got busy=%b ack=%b req=%b exp 0 0 0", busy_o, ack_sent_o, req_o); end
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL single_proto got=%b exp=0", proto_err_o); end
  endtask

  // Three done pulses, grant given whenever req_o is high.
  task automatic test_burst();
    logic exp_req [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_ack [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int   n_ack = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      done_i             = (k < 3);
      ack_ready_i        = req_o;
      ack_event_i        = 1'b1;
      winner_source_id_i = 2'b01;
      tick();
      if (ack_sent_o === 1'b1) n_ack++;
      checks++; if (req_o !== exp_req[k] || ack_sent_o !== exp_ack[k]) begin errors++; $display("FAIL burst_step%0d got req=%b ack=%b exp req=%b ack=%b", k, req_o, ack_sent_o, exp_req[k], exp_ack[k]); end
    end
    idle_inputs();
    checks++; if (n_ack != 3) begin errors++; $display("FAIL burst_ack_count got=%0d exp=3", n_ack); end
    checks++; if (pend_cnt_o !== 2'd0 || proto_err_o !== 1'b0) begin errors++; $display("FAIL burst_end got pend=%0d proto=%b exp pend=0 proto=0", pend_cnt_o, proto_err_o); end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_pend [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      done_i = 1'b1;
      tick();
      checks++; if (pend_cnt_o !== exp_pend[k]) begin errors++; $display("FAIL ovf_pend%0d got=%0d exp=%0d", k, pend_cnt_o, exp_pend[k]); end
    end
    done_i = 1'b0;
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checks++; if (overflow_o !== 1'b0 || pend_cnt_o !== 2'd3) begin errors++; $display("FAIL ovf_clr got ovf=%b pend=%0d exp ovf=0 pend=3", overflow_o, pend_cnt_o); end
    // done at full count together with accept: count holds, no overflow.
    done_i = 1'b1;
    grant_good();
    tick();
    idle_inputs();
    checks++; if (pend_cnt_o !== 2'd3 || overflow_o !== 1'b0 || ack_sent_o !== 1'b1) begin errors++; $display("FAIL ovf_full_accept got pend=%0d ovf=%b ack=%b exp 3 0 1", pend_cnt_o, overflow_o, ack_sent_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    done_i = 1'b1;
    tick();
    tick();
    checks++; if (pend_cnt_o !== 2'd2 || req_o !== 1'b1) begin errors++; $display("FAIL simul_setup got pend=%0d req=%b exp pend=2 req=1", pend_cnt_o, req_o); end
    grant_good();
    tick();
    idle_inputs();
    checks++; if (pend_cnt_o !== 2'd2 || ack_sent_o !== 1'b1 || req_o !== 1'b0) begin errors++; $display("FAIL simul_accept got pend=%0d ack=%b req=%b exp 2 1 0", pend_cnt_o, ack_sent_o, req_o); end
    tick();
    checks++; if (ack_sent_o !== 1'b0 || req_o !== 1'b1) begin errors++; $display("FAIL simul_gap_exit got ack=%b req=%b exp ack=0 req=1", ack_sent_o, req_o); end
  endtask

  task automatic test_timeout_proto();
    do_reset();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", timeout_o); end
    tick();
    checks++; if (timeout_o !== 1'b1 || req_o !== 1'b1) begin errors++; $display("FAIL timeout_set got to=%b req=%b exp to=1 req=1", timeout_o, req_o); end
    // Wrong winner, with clr in the same cycle: proto error set wins, timeout clears.
    ack_ready_i        = 1'b1;
    ack_event_i        = 1'b1;
    winner_source_id_i = 2'b10;
    clr_i              = 1'b1;
    tick();
    idle_inputs();
    checks++; if (proto_err_o !== 1'b1 || ack_sent_o !== 1'b0) begin errors++; $display("FAIL proto_winner got proto=%b ack=%b exp proto=1 ack=0", proto_err_o, ack_sent_o); end
    checks++; if (timeout_o !== 1'b0 || pend_cnt_o !== 2'd1 || req_o !== 1'b1) begin errors++; $display("FAIL proto_side got to=%b pend=%0d req=%b exp 0 1 1", timeout_o, pend_cnt_o, req_o); end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL proto_clr got=%b exp=0", proto_err_o); end
    // Correct winner but event qualifier low is also a protocol error.
    ack_ready_i        = 1'b1;
    winner_source_id_i = 2'b01;
    tick();
    idle_inputs();
    checks++; if (proto_err_o !== 1'b1 || ack_sent_o !== 1'b0 || pend_cnt_o !== 2'd1) begin errors++; $display("FAIL proto_event got proto=%b ack=%b pend=%0d exp 1 0 1", proto_err_o, ack_sent_o, pend_cnt_o); end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    done_i = 1'b1;
    tick();
    tick();
    done_i      = 1'b0;
    ack_ready_i = 1'b1;
    tick();
    idle_inputs();
    checks++; if (pend_cnt_o !== 2'd2 || proto_err_o !== 1'b1 || req_o !== 1'b1) begin errors++; $display("FAIL midreq_setup got pend=%0d proto=%b req=%b exp 2 1 1", pend_cnt_o, proto_err_o, req_o); end
    rst_n  = 1'b0;
    done_i = 1'b1;
    tick();
    checks++; if (req_o !== 1'b0 || pend_cnt_o !== 2'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL midreq_reset got req=%b pend=%0d busy=%b exp 0 0 0", req_o, pend_cnt_o, busy_o); end
    checks++; if ({overflow_o, timeout_o, proto_err_o, ack_sent_o} !== 4'b0000) begin errors++; $display("FAIL midreq_flags got=%b exp=0000", {overflow_o, timeout_o, proto_err_o, ack_sent_o}); end
    rst_n  = 1'b1;
    done_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_ack();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_timeout_proto();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
